// File: rtl/inst_encoder_pkg.sv
// Shared constants for inst_encoder: widths, field-bundle kind codes,
// RV32I opcodes and funct3 values, and an immediate range helper.
package inst_encoder_pkg;

   localparam int XLEN         = 32;
   localparam int REG_ADDR_LEN = 5;
   localparam int ENC_KIND_LEN = 4;

   // Kind codes carried on in_kind; codes 10..15 are unknown and rejected.
   typedef enum logic [ENC_KIND_LEN-1:0] {
      ENC_KIND_LOAD   = 4'd0,
      ENC_KIND_STORE  = 4'd1,
      ENC_KIND_BRANCH = 4'd2,
      ENC_KIND_JAL    = 4'd3,
      ENC_KIND_JALR   = 4'd4,
      ENC_KIND_OP_IMM = 4'd5,
      ENC_KIND_OP     = 4'd6,
      ENC_KIND_SYSTEM = 4'd7,
      ENC_KIND_AUIPC  = 4'd8,
      ENC_KIND_LUI    = 4'd9
   } enc_kind_e;

   // RV32I major opcodes.
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   // funct3 values the encoder has to recognise.
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SRA_SRL = 3'b101;
   localparam logic [2:0] F3_JALR    = 3'b000;

   // True when v is representable as an n-bit two's complement value.
   function automatic logic fits_signed(input logic [XLEN-1:0] v, input int n);
      logic [XLEN-1:0] s;
      s = XLEN'($signed(v) >>> (n - 1));
      return (s == '0) || (s == '1);
   endfunction

endpackage

// File: rtl/inst_encoder_fifo2.sv
// enc_fifo2: two-entry FIFO holding encoded words. Push is ignored when
// full, pop is ignored when empty, flush empties it in one cycle.
module enc_fifo2 #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic [1:0]   count
);

   logic [W-1:0] mem0, mem1;
   logic         wr_ptr, rd_ptr;
   logic         do_push, do_pop;

   // Qualify requests against occupancy.
   always_comb begin
      do_push = push && (count != 2'd2);
      do_pop  = pop  && (count != 2'd0);
      head    = rd_ptr ? mem1 : mem0;
   end

   // Storage, pointers and occupancy count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem0   <= '0;
         mem1   <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            if (wr_ptr) mem1 <= push_data;
            else        mem0 <= push_data;
            wr_ptr <= ~wr_ptr;
         end
         if (do_pop) rd_ptr <= ~rd_ptr;
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded RV32I field bundles into instruction words and
// streams them to an instruction-memory write port at sequential addresses.
// Optional build macro: INST_ENCODER_RANGE_CHECK_EN rejects out-of-range
// immediates; without it immediates are truncated to the format's bits.
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// producer holds its payload stable while valid && !ready.
module inst_encoder
   import inst_encoder_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [XLEN-1:0]         start_addr,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [ENC_KIND_LEN-1:0] in_kind,
   input  logic [2:0]              in_funct3,
   input  logic                    in_alt,
   input  logic [REG_ADDR_LEN-1:0] in_rd,
   input  logic [REG_ADDR_LEN-1:0] in_rs1,
   input  logic [REG_ADDR_LEN-1:0] in_rs2,
   input  logic [XLEN-1:0]         in_imm,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [XLEN-1:0]         out_addr,
   output logic [XLEN-1:0]         out_data,
   output logic                    error,
   output logic [15:0]             words
);

   logic [XLEN-1:0] enc_word;
   logic            enc_reject;
   logic            imm_ok;
   logic [6:0]      funct7;
   logic [XLEN-1:0] head;
   logic [1:0]      count;
   logic            accept, push, pop;
   logic [XLEN-1:0] addr_q;

   // Encode the presented bundle and decide whether it is rejected.
   always_comb begin
      enc_word   = '0;
      enc_reject = 1'b0;
      imm_ok     = 1'b1;
      funct7     = {1'b0, in_alt, 5'b0};
      case (in_kind)
         ENC_KIND_LOAD: begin
            enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD};
            imm_ok   = fits_signed(in_imm, 12);
         end
         ENC_KIND_STORE: begin
            enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OPC_STORE};
            imm_ok   = fits_signed(in_imm, 12);
         end
         ENC_KIND_BRANCH: begin
            enc_word   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:1], in_imm[11], OPC_BRANCH};
            enc_reject = (in_funct3 == 3'b010) || (in_funct3 == 3'b011);
            imm_ok     = fits_signed(in_imm, 13) && !in_imm[0];
         end
         ENC_KIND_JAL: begin
            enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
            imm_ok   = fits_signed(in_imm, 21) && !in_imm[0];
         end
         ENC_KIND_JALR: begin
            enc_word   = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_JALR};
            enc_reject = (in_funct3 != F3_JALR);
            imm_ok     = fits_signed(in_imm, 12);
         end
         ENC_KIND_OP_IMM: begin
            if (in_funct3 == F3_SLL || in_funct3 == F3_SRA_SRL) begin
               // SLLI has no arithmetic variant, so its funct7 is always zero.
               if (in_funct3 == F3_SLL) funct7 = 7'b0;
               enc_word = {funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, OPC_OP_IMM};
               imm_ok   = (in_imm[XLEN-1:5] == '0);
            end else begin
               enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_OP_IMM};
               imm_ok   = fits_signed(in_imm, 12);
            end
         end
         ENC_KIND_OP: begin
            enc_word = {funct7, in_rs2, in_rs1, in_funct3, in_rd, OPC_OP};
         end
         ENC_KIND_SYSTEM: begin
            // CSR address is an unsigned 12-bit field, not a signed offset.
            enc_word   = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_SYSTEM};
            enc_reject = (in_funct3 == 3'b000) || (in_funct3 == 3'b100);
            imm_ok     = (in_imm[XLEN-1:12] == '0);
         end
         ENC_KIND_AUIPC: begin
            enc_word = {in_imm[31:12], in_rd, OPC_AUIPC};
            imm_ok   = (in_imm[11:0] == '0);
         end
         ENC_KIND_LUI: begin
            enc_word = {in_imm[31:12], in_rd, OPC_LUI};
            imm_ok   = (in_imm[11:0] == '0);
         end
         default: begin
            enc_reject = 1'b1;
         end
      endcase
`ifdef INST_ENCODER_RANGE_CHECK_EN
      if (!imm_ok) enc_reject = 1'b1;
`else
      imm_ok = 1'b1;
`endif
   end

   // Handshake qualification; a full FIFO blocks input even while popping.
   always_comb begin
      in_ready  = !start && (count != 2'd2);
      accept    = in_valid && in_ready;
      push      = accept && !enc_reject;
      out_valid = (count != 2'd0);
      pop       = out_valid && out_ready;
      out_addr  = addr_q;
      out_data  = out_valid ? head : '0;
   end

   enc_fifo2 #(.W(XLEN)) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (start),
      .push      (push),
      .push_data (enc_word),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

   // Address counter, emitted-word counter and sticky error flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q <= '0;
         words  <= 16'd0;
         error  <= 1'b0;
      end else if (start) begin
         addr_q <= start_addr & ~XLEN'(3);
         words  <= 16'd0;
         error  <= 1'b0;
      end else begin
         if (pop) begin
            addr_q <= addr_q + XLEN'(4);
            if (words != 16'hFFFF) words <= words + 16'd1;
         end
         if (accept && enc_reject) error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: a driver issues field bundles and pushes
// the hand-computed {address, word} into exp_q; a monitor pops and compares
// every write the DUT performs.
module tb_inst_encoder;
   import inst_encoder_pkg::*;

   logic                    clk = 1'b0;
   logic                    reset_n;
   logic                    start;
   logic [XLEN-1:0]         start_addr;
   logic                    in_valid;
   logic                    in_ready;
   logic [ENC_KIND_LEN-1:0] in_kind;
   logic [2:0]              in_funct3;
   logic                    in_alt;
   logic [REG_ADDR_LEN-1:0] in_rd, in_rs1, in_rs2;
   logic [XLEN-1:0]         in_imm;
   logic                    out_valid;
   logic                    out_ready;
   logic [XLEN-1:0]         out_addr, out_data;
   logic                    error;
   logic [15:0]             words;

   logic [63:0]     exp_q[$];
   logic [XLEN-1:0] exp_addr_next;
   int              exp_words;
   int              n_cmp = 0;
   int              n_err = 0;
   logic            rng_rej;

   inst_encoder dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .start_addr (start_addr),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_kind    (in_kind),
      .in_funct3  (in_funct3),
      .in_alt     (in_alt),
      .in_rd      (in_rd),
      .in_rs1     (in_rs1),
      .in_rs2     (in_rs2),
      .in_imm     (in_imm),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_addr   (out_addr),
      .out_data   (out_data),
      .error      (error),
      .words      (words)
   );

   // Clock: 10 time-unit period.
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every write handshake must match the head of exp_q.
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write", out_addr, out_data);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("out_addr", out_addr, e[63:32]);
            chk("out_data", out_data, e[31:0]);
            exp_words++;
         end
      end
   end

   task automatic do_start(input logic [31:0] addr);
      @(negedge clk);
      start      = 1'b1;
      start_addr = addr;
      @(negedge clk);
      start = 1'b0;
      exp_q.delete();
      exp_addr_next = addr & 32'hFFFF_FFFC;
      exp_words     = 0;
   endtask

   // Offer one bundle; rej=1 means the DUT must accept but not emit it.
   task automatic send(input logic [3:0] kind, input logic [2:0] f3, input logic alt,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm, input logic rej, input logic [31:0] word);
      int i;
      @(negedge clk);
      in_kind = kind; in_funct3 = f3; in_alt = alt;
      in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      in_valid = 1'b1;
      i = 0;
      while (!in_ready && i < 50) begin
         @(negedge clk);
         i++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_err++;
         $display("FAIL ready_timeout: got in_ready 0 expected 1 within 50 cycles");
      end else begin
         if (!rej) begin
            exp_q.push_back({exp_addr_next, word});
            exp_addr_next = exp_addr_next + 32'd4;
         end
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int i;
      i = 0;
      while ((exp_q.size() != 0 || out_valid) && i < 50) begin
         @(negedge clk);
         i++;
      end
      chk("drain_pending", exp_q.size(), 0);
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; start_addr = '0; in_valid = 1'b0;
      in_kind = '0; in_funct3 = '0; in_alt = 1'b0; in_rd = '0; in_rs1 = '0;
      in_rs2 = '0; in_imm = '0; out_ready = 1'b1;
      exp_addr_next = '0; exp_words = 0;
`ifdef INST_ENCODER_RANGE_CHECK_EN
      rng_rej = 1'b1;
`else
      rng_rej = 1'b0;
`endif
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_addr", out_addr, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_error", error, 0);
      chk("rst_words", words, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Basic encodings and first-word latency.
      do_start(32'h0);
      send(ENC_KIND_OP_IMM, 3'b000, 0, 5'd1, 5'd0, 5'd0, 32'd5, 0, 32'h00500093);
      chk("latency_valid", out_valid, 1);
      send(ENC_KIND_OP, 3'b000, 1, 5'd3, 5'd1, 5'd2, 32'd0, 0, 32'h402081B3);
      send(ENC_KIND_LUI, 3'b000, 0, 5'd5, 5'd0, 5'd0, 32'h12345000, 0, 32'h123452B7);
      send(ENC_KIND_BRANCH, 3'b000, 0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 0, 32'hFE000EE3);
      wait_drain();
      chk("error_clean", error, 0);
      send(ENC_KIND_BRANCH, 3'b010, 0, 5'd0, 5'd0, 5'd0, 32'd8, 1, 32'h0);
      chk("error_branch_f3", error, 1);
      send(ENC_KIND_OP_IMM, 3'b101, 1, 5'd1, 5'd2, 5'd0, 32'd3, 0, 32'h40315093);
      send(ENC_KIND_OP_IMM, 3'b001, 1, 5'd1, 5'd2, 5'd0, 32'd3, 0, 32'h00311093);
      send(ENC_KIND_JAL, 3'b000, 0, 5'd1, 5'd0, 5'd0, 32'd8, 0, 32'h008000EF);
      send(ENC_KIND_STORE, 3'b010, 0, 5'd0, 5'd1, 5'd2, 32'd4, 0, 32'h0020A223);
      send(ENC_KIND_JALR, 3'b001, 0, 5'd1, 5'd2, 5'd0, 32'd0, 1, 32'h0);
      send(4'd12, 3'b000, 0, 5'd1, 5'd2, 5'd0, 32'd0, 1, 32'h0);
      send(ENC_KIND_OP_IMM, 3'b000, 0, 5'd1, 5'd0, 5'd0, 32'd2048, rng_rej, 32'h80000093);
      wait_drain();
      chk("words_after_mix", words, exp_words);

      // Back-pressure: two buffered, third blocked until the consumer drains.
      do_start(32'h0000_0102);
      chk("start_clears_error", error, 0);
      chk("start_addr_aligned", out_addr, 32'h100);
      out_ready = 1'b0;
      send(ENC_KIND_OP_IMM, 3'b000, 0, 5'd1, 5'd0, 5'd0, 32'd5, 0, 32'h00500093);
      send(ENC_KIND_LUI, 3'b000, 0, 5'd5, 5'd0, 5'd0, 32'h12345000, 0, 32'h123452B7);
      chk("full_in_ready", in_ready, 0);
      chk("stall_addr", out_addr, 32'h100);
      out_ready = 1'b1;
      chk("no_ready_through", in_ready, 0);
      send(ENC_KIND_JAL, 3'b000, 0, 5'd1, 5'd0, 5'd0, 32'd8, 0, 32'h008000EF);
      wait_drain();
      chk("words_three", words, 3);

      // start wins over a simultaneous bundle; address wraps past 2^32.
      @(negedge clk);
      in_kind = ENC_KIND_OP_IMM; in_funct3 = 3'b000; in_rd = 5'd1; in_imm = 32'd5;
      in_valid = 1'b1; start = 1'b1; start_addr = 32'hFFFF_FFFC;
      #1;
      chk("start_blocks_ready", in_ready, 0);
      @(negedge clk);
      start = 1'b0; in_valid = 1'b0;
      exp_q.delete(); exp_addr_next = 32'hFFFF_FFFC; exp_words = 0;
      chk("start_words", words, 0);
      chk("start_nothing_out", out_valid, 0);
      send(ENC_KIND_OP_IMM, 3'b000, 0, 5'd1, 5'd0, 5'd0, 32'd5, 0, 32'h00500093);
      send(ENC_KIND_JAL, 3'b000, 0, 5'd1, 5'd0, 5'd0, 32'd8, 0, 32'h008000EF);
      wait_drain();
      chk("wrap_addr", out_addr, 32'h4);

      // Asynchronous reset with two words buffered.
      out_ready = 1'b0;
      send(ENC_KIND_OP_IMM, 3'b000, 0, 5'd1, 5'd0, 5'd0, 32'd5, 0, 32'h00500093);
      send(ENC_KIND_LUI, 3'b000, 0, 5'd5, 5'd0, 5'd0, 32'h12345000, 0, 32'h123452B7);
      chk("pre_reset_valid", out_valid, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_words", words, 0);
      chk("async_rst_addr", out_addr, 0);
      chk("async_rst_ready", in_ready, 1);
      exp_q.delete(); exp_addr_next = '0; exp_words = 0;
      @(negedge clk);
      reset_n = 1'b1;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_reset_empty", out_valid, 0);
      chk("final_queue", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
